// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory between the 6502 core and a
// DMA/debug loader port. One access is granted per cycle through a
// combinational grant; read data and completion come back one cycle later.
//
// Arbitration on contention:
//   MEM_ARB_RR_EN undefined (default): the core wins unless the DMA port has
//     been denied STARVE_LIMIT consecutive requesting cycles, then DMA wins.
//   MEM_ARB_RR_EN defined: strict alternation between the two requesters;
//     the first contended cycle after reset goes to the core.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  // Winner encoding shared by owner and the alternation state.
  localparam logic WIN_CORE = 1'b0;
  localparam logic WIN_DMA  = 1'b1;

  logic contended;
  logic dma_pri;       // DMA takes a contended cycle
  logic core_rvalid_q;
  logic dma_rvalid_q;

  assign contended = core_req && dma_req;

`ifdef MEM_ARB_RR_EN
  logic last_winner;   // winner of the most recent contended cycle

  assign dma_pri = (last_winner == WIN_CORE);

  // Remember who won the last contended cycle so the other side goes next.
  always_ff @(posedge ph1) begin
    if (reset) begin
      last_winner <= WIN_DMA;
    end else if (contended) begin
      last_winner <= dma_gnt ? WIN_DMA : WIN_CORE;
    end
  end
`else
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] dma_wait;  // consecutive denied DMA request cycles

  assign dma_pri = (dma_wait == WAIT_MAX);

  // Count denied DMA cycles (saturating); a grant clears, idle DMA holds.
  always_ff @(posedge ph1) begin
    if (reset) begin
      dma_wait <= '0;
    end else if (dma_gnt) begin
      dma_wait <= '0;
    end else if (dma_req && (dma_wait != WAIT_MAX)) begin
      dma_wait <= dma_wait + 1'b1;
    end
  end
`endif

  // Grant decision from current requests and registered arbitration state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (!reset) begin
      if (contended) begin
        if (dma_pri) dma_gnt  = 1'b1;
        else         core_gnt = 1'b1;
      end else begin
        core_gnt = core_req;
        dma_gnt  = dma_req;
      end
    end
  end

  // Steer the winner's access onto the memory port; idle bus drives zeros.
  always_comb begin
    mem_en    = core_gnt | dma_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // Completion flags one cycle after each grant, plus the last-owner record.
  always_ff @(posedge ph1) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      core_rvalid_q <= 1'b0;
      dma_rvalid_q  <= 1'b0;
      owner         <= WIN_CORE;
    end else begin
      core_rvalid_q <= core_gnt;
      dma_rvalid_q  <= dma_gnt;
      if (mem_en) owner <= dma_gnt ? WIN_DMA : WIN_CORE;
    end
  end

  // An access accepted just before reset must not complete while reset is
  // high, so the registered flags are masked by reset on the way out.
  assign core_rvalid = core_rvalid_q & ~reset;
  assign dma_rvalid  = dma_rvalid_q & ~reset;
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign dma_rdata   = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small behavioural memory.
// Build with +define+MEM_ARB_RR_EN to exercise the alternating arbiter.
module tb_mem_bus_arbiter;

  logic        ph1 = 1'b0;
  logic        reset;
  logic        core_req, core_we, dma_req, dma_we;
  logic [15:0] core_addr, dma_addr;
  logic [7:0]  core_wdata, dma_wdata;
  logic        core_gnt, core_rvalid, dma_gnt, dma_rvalid;
  logic [7:0]  core_rdata, dma_rdata;
  logic        mem_en, mem_we, owner;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  logic [7:0]  ram [0:65535];

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_LIMIT(3)) dut (
    .ph1(ph1), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 ph1 = ~ph1;

  // Synchronous memory: read data one cycle after mem_en, zero after a write.
  always @(posedge ph1) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        mem_rdata     <= 8'h00;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic go();
    @(posedge ph1);
    #1;
  endtask

  task automatic look();
    @(negedge ph1);
  endtask

  // Expected per-cycle grants for the mixed contention table.
`ifdef MEM_ARB_RR_EN
  localparam logic [8:0] MIX_CORE = 9'b101101010;
`else
  localparam logic [8:0] MIX_CORE = 9'b011110111;
`endif
  localparam logic [8:0] MIX_DREQ = 9'b110111111;

  initial begin
    logic exp_d;
    logic [8:0] mix_core, mix_dreq;
    mix_core = MIX_CORE;
    mix_dreq = MIX_DREQ;

    for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
    ram[16'h0030] = 8'h9D;

    // Reset with both requesting: nothing may be granted.
    reset = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0030; core_wdata = 8'h00;
    dma_req  = 1'b1; dma_we  = 1'b0; dma_addr  = 16'h0100; dma_wdata  = 8'h00;
    look();
    check("rst core_gnt", 32'(core_gnt), 32'd0);
    check("rst dma_gnt",  32'(dma_gnt),  32'd0);
    check("rst mem_en",   32'(mem_en),   32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    go();
    look();
    check("rst owner",       32'(owner),       32'd0);
    check("rst core_rvalid", 32'(core_rvalid), 32'd0);
    check("rst dma_rvalid",  32'(dma_rvalid),  32'd0);
    check("rst core_rdata",  32'(core_rdata),  32'd0);
    go();
    reset = 1'b0; core_req = 1'b0; dma_req = 1'b0;

    // 1: core-only read of 0x0030.
    core_req = 1'b1; core_addr = 16'h0030;
    look();
    check("t1 core_gnt", 32'(core_gnt), 32'd1);
    check("t1 dma_gnt",  32'(dma_gnt),  32'd0);
    check("t1 mem_en",   32'(mem_en),   32'd1);
    check("t1 mem_we",   32'(mem_we),   32'd0);
    check("t1 mem_addr", 32'(mem_addr), 32'h0030);
    go();
    core_req = 1'b0;
    look();
    check("t1 core_rvalid", 32'(core_rvalid), 32'd1);
    check("t1 core_rdata",  32'(core_rdata),  32'h9D);
    check("t1 idle mem_en", 32'(mem_en),      32'd0);
    check("t1 owner",       32'(owner),       32'd0);
    go();

    // 2 / 6: continuous contention straight out of reset.
    reset = 1'b1;
    go();
    reset = 1'b0;
    core_req = 1'b1; core_addr = 16'h0030;
    dma_req  = 1'b1; dma_addr  = 16'h0100;
    for (int i = 0; i < 8; i++) begin
      look();
`ifdef MEM_ARB_RR_EN
      exp_d = (i % 2) == 1;
`else
      exp_d = (i % 4) == 3;
`endif
      check($sformatf("t2 core_gnt c%0d", i), 32'(core_gnt), 32'(!exp_d));
      check($sformatf("t2 dma_gnt c%0d", i),  32'(dma_gnt),  32'(exp_d));
      check($sformatf("t2 mem_en c%0d", i),   32'(mem_en),   32'd1);
      check($sformatf("t2 mem_addr c%0d", i), 32'(mem_addr), exp_d ? 32'h0100 : 32'h0030);
      go();
    end
    core_req = 1'b0; dma_req = 1'b0;
    look();
    check("t2 owner",       32'(owner),       32'd1);
    check("t2 dma_rvalid",  32'(dma_rvalid),  32'd1);
    check("t2 core_rvalid", 32'(core_rvalid), 32'd0);
    go();

    // 3: DMA write then core read of the same location.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 8'h55;
    look();
    check("t3 dma_gnt",   32'(dma_gnt),   32'd1);
    check("t3 mem_we",    32'(mem_we),    32'd1);
    check("t3 mem_addr",  32'(mem_addr),  32'h0200);
    check("t3 mem_wdata", 32'(mem_wdata), 32'h55);
    go();
    dma_req = 1'b0; dma_we = 1'b0; dma_wdata = 8'h00;
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0200;
    look();
    check("t3 dma_rvalid", 32'(dma_rvalid), 32'd1);
    check("t3 dma_rdata",  32'(dma_rdata),  32'd0);
    check("t3 core_gnt",   32'(core_gnt),   32'd1);
    check("t3 owner dma",  32'(owner),      32'd1);
    check("t3 rd mem_we",  32'(mem_we),     32'd0);
    go();
    core_req = 1'b0;
    look();
    check("t3 core_rvalid", 32'(core_rvalid), 32'd1);
    check("t3 core_rdata",  32'(core_rdata),  32'h55);
    check("t3 dma_rvalid0", 32'(dma_rvalid),  32'd0);
    check("t3 owner core",  32'(owner),       32'd0);
    go();

    // 4: core read accepted, then reset the next cycle.
    core_req = 1'b1; core_addr = 16'h0030; dma_req = 1'b1; dma_addr = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      look();
      if (i == 2) check("t4 core_gnt pre", 32'(core_gnt), 32'd1);
      go();
    end
    reset = 1'b1;
    look();
    check("t4 rst core_rvalid", 32'(core_rvalid), 32'd0);
    check("t4 rst core_rdata",  32'(core_rdata),  32'd0);
    check("t4 rst core_gnt",    32'(core_gnt),    32'd0);
    check("t4 rst dma_gnt",     32'(dma_gnt),     32'd0);
    check("t4 rst mem_en",      32'(mem_en),      32'd0);
    go();
    reset = 1'b0; core_req = 1'b0; dma_req = 1'b0;
    look();
    check("t4 post core_rvalid", 32'(core_rvalid), 32'd0);
    check("t4 post dma_rvalid",  32'(dma_rvalid),  32'd0);
    check("t4 post mem_en",      32'(mem_en),      32'd0);
    check("t4 post mem_we",      32'(mem_we),      32'd0);
    check("t4 post mem_addr",    32'(mem_addr),    32'd0);
    check("t4 post mem_wdata",   32'(mem_wdata),   32'd0);
    check("t4 post owner",       32'(owner),       32'd0);
    go();
    core_req = 1'b1; dma_req = 1'b1;
    look();
    check("t4 first contended", 32'(core_gnt), 32'd1);
    go();
    core_req = 1'b0;

    // 5: DMA alone is granted every cycle.
    for (int i = 0; i < 4; i++) begin
      look();
      check($sformatf("t5 dma_gnt c%0d", i), 32'(dma_gnt), 32'd1);
      check($sformatf("t5 mem_en c%0d", i),  32'(mem_en),  32'd1);
      if (i > 0) check($sformatf("t5 owner c%0d", i), 32'(owner), 32'd1);
      go();
    end

    // Mixed contention with one core-only cycle in the middle.
    core_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      dma_req = mix_dreq[i];
      look();
      check($sformatf("mix core_gnt c%0d", i), 32'(core_gnt), 32'(mix_core[i]));
      check($sformatf("mix dma_gnt c%0d", i),  32'(dma_gnt),  32'(mix_dreq[i] & ~mix_core[i]));
      check($sformatf("mix mem_en c%0d", i),   32'(mem_en),   32'd1);
      go();
    end
    core_req = 1'b0; dma_req = 1'b0;
    go();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
